imem_arbiter: RTL and testbench

Sequential arbiter that shares the single-ported instruction memory between the fetch stage (instruction reads) and the data-side port (loads/stores to instruction space, program loading). It sits between the fetch stage, the memory stage and the instruction memory. It serialises their accesses over a req/ack memory handshake with one outstanding transaction. The data port has priority, and a streak counter guarantees fetch forward progress.

---
 rtl/imem_arbiter.sv | 141 ++++++++++++++
 tb/tb_imem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Two-port arbiter for the single-ported instruction memory: fetch vs. data side.
// The data side has priority; a streak counter bounds how long a waiting fetch can be held off.
module imem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_done,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  typedef enum logic {
    OWN_F,
    OWN_D
  } owner_t;

  localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_D_STREAK);

  state_t        r_state;
  owner_t        r_owner;
  logic [3:0]    r_d_streak;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_f_done;
  logic          r_d_done;
  logic [DW-1:0] r_f_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_busy;

  logic          w_grant_d;
  logic          w_grant_f;

  // Data wins a tie unless it has already used its full streak while fetch waited.
  always_comb begin
    w_grant_d = d_req && (!f_req || (r_d_streak != LP_MAX_STREAK));
    w_grant_f = f_req && !w_grant_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_F;
      r_d_streak  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_f_done    <= 1'b0;
      r_d_done    <= 1'b0;
      r_f_rdata   <= '0;
      r_d_rdata   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_f_done <= 1'b0;
      r_d_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_owner     <= OWN_D;
            r_mem_addr  <= d_addr;
            r_mem_we    <= d_we;
            r_mem_wdata <= d_wdata;
            r_mem_req   <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_ACCESS;
            r_d_streak  <= f_req ? (r_d_streak + 4'd1) : '0;
          end else if (w_grant_f) begin
            r_owner     <= OWN_F;
            r_mem_addr  <= f_addr;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_req   <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_ACCESS;
            r_d_streak  <= '0;
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_DONE;
            if (r_owner == OWN_F) begin
              r_f_rdata <= mem_rdata;
              r_f_done  <= 1'b1;
            end else begin
              if (!r_mem_we) begin
                r_d_rdata <= mem_rdata;
              end
              r_d_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign f_done    = r_f_done;
  assign f_rdata   = r_f_rdata;
  assign d_done    = r_d_done;
  assign d_rdata   = r_d_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: directed vectors push expected memory requests and
// done responses; independent monitors pop and compare when the DUT presents them.
module tb_imem_arbiter;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_done;
  logic [31:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  logic        auto_ack;
  logic        man_ack;
  int          lat;
  int          cnt;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } mreq_t;

  done_t       exp_done[$];
  mreq_t       exp_mem[$];
  logic [31:0] mem[logic [31:0]];

  int n_checks = 0;
  int n_fail   = 0;

  imem_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ack = auto_ack | man_ack;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Memory model: ack on the lat-th cycle of mem_req (lat==0: never ack).
  initial begin
    auto_ack  = 1'b0;
    mem_rdata = '0;
    cnt       = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req && lat != 0) begin
        cnt++;
        if (cnt == lat) begin
          auto_ack = 1'b1;
          cnt      = 0;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'hFFFF_FFFF;
        end else begin
          auto_ack = 1'b0;
        end
      end else begin
        auto_ack = 1'b0;
        cnt      = 0;
      end
    end
  end

  // Done monitor.
  initial begin
    done_t e;
    forever begin
      @(negedge clk);
      if (f_done || d_done) begin
        if (f_done && d_done) chk("both_done", 32'd1, 32'd0);
        if (exp_done.size() == 0) begin
          chk("done_unexpected", {30'd0, f_done, d_done}, 32'd0);
        end else begin
          e = exp_done.pop_front();
          chk("done_port", {31'd0, d_done}, {31'd0, e.is_d});
          chk("done_rdata", e.is_d ? d_rdata : f_rdata, e.rdata);
        end
      end
    end
  end

  // Memory request monitor: pops on the first cycle, checks stability every cycle.
  initial begin
    mreq_t cur;
    logic  prev;
    prev = 1'b0;
    cur  = '{addr: '0, we: 1'b0, wdata: '0};
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (!prev) begin
          if (exp_mem.size() == 0) chk("mem_req_unexpected", 32'd1, 32'd0);
          else cur = exp_mem.pop_front();
        end
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
        chk("mem_wdata", mem_wdata, cur.wdata);
      end
      prev = (mem_req === 1'b1);
    end
  end

  task automatic single(input logic is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    bit seen;
    seen = 0;
    step();
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    for (int i = 0; i < 50; i++) begin
      smp();
      if (is_d ? d_done : f_done) begin
        seen = 1;
        break;
      end
      step();
    end
    if (!seen) chk("single_timeout", 32'd0, 32'd1);
    step();
    if (is_d) d_req = 1'b0;
    else      f_req = 1'b0;
  endtask

  initial begin
    bit fs, ds;
    int fcnt;
    rst = 1'b1; f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    man_ack = 1'b0; lat = 1;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h44]  = 32'h0BADF00D;
    mem[32'h200] = 32'h22220000;
    mem[32'h300] = 32'h33330000;
    step(); step();
    smp();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_f_done", {31'd0, f_done}, 32'd0);
    chk("rst_d_done", {31'd0, d_done}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_f_rdata", f_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    step(); rst = 1'b0;

    // Single fetch, 2-cycle latency.
    lat = 2;
    exp_mem.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0});
    exp_done.push_back('{is_d: 1'b0, rdata: 32'hDEADBEEF});
    step(); f_addr = 32'h100; f_req = 1'b1;
    smp(); chk("f_c0_busy", {31'd0, busy}, 32'd0);
    step(); smp();
    chk("f_c1_req", {31'd0, mem_req}, 32'd1);
    chk("f_c1_busy", {31'd0, busy}, 32'd1);
    chk("f_c1_done", {31'd0, f_done}, 32'd0);
    step(); smp();
    chk("f_c2_req", {31'd0, mem_req}, 32'd1);
    chk("f_c2_done", {31'd0, f_done}, 32'd0);
    step(); smp();
    chk("f_c3_done", {31'd0, f_done}, 32'd1);
    chk("f_c3_rdata", f_rdata, 32'hDEADBEEF);
    chk("f_c3_req", {31'd0, mem_req}, 32'd0);
    chk("f_c3_busy", {31'd0, busy}, 32'd1);
    step(); f_req = 1'b0;
    smp();
    chk("f_c4_done", {31'd0, f_done}, 32'd0);
    chk("f_c4_busy", {31'd0, busy}, 32'd0);

    // Data read to load d_rdata.
    lat = 1;
    exp_mem.push_back('{addr: 32'h44, we: 1'b0, wdata: 32'h0});
    exp_done.push_back('{is_d: 1'b1, rdata: 32'h0BADF00D});
    single(1'b1, 1'b0, 32'h44, 32'h0);

    // Data write, 0-wait: d_rdata must keep the previous read value.
    exp_mem.push_back('{addr: 32'h40, we: 1'b1, wdata: 32'h12345678});
    exp_done.push_back('{is_d: 1'b1, rdata: 32'h0BADF00D});
    step(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
    step(); smp();
    chk("w_c1_we", {31'd0, mem_we}, 32'd1);
    chk("w_c1_wdata", mem_wdata, 32'h12345678);
    step(); smp();
    chk("w_c2_done", {31'd0, d_done}, 32'd1);
    chk("w_c2_rdata", d_rdata, 32'h0BADF00D);
    step(); d_req = 1'b0; d_we = 1'b0;
    smp(); chk("w_c3_done", {31'd0, d_done}, 32'd0);

    // Simultaneous requests: D first, then F.
    exp_mem.push_back('{addr: 32'h40, we: 1'b0, wdata: 32'hCAFE0003});
    exp_mem.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0});
    exp_done.push_back('{is_d: 1'b1, rdata: 32'h12345678});
    exp_done.push_back('{is_d: 1'b0, rdata: 32'hDEADBEEF});
    step(); d_req = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE0003; f_req = 1'b1; f_addr = 32'h100;
    fs = 0; ds = 0;
    for (int i = 0; i < 100; i++) begin
      bit gf, gd;
      smp(); gf = f_done; gd = d_done;
      step();
      if (gd) begin d_req = 1'b0; ds = 1; end
      if (gf) begin f_req = 1'b0; fs = 1; end
      if (fs && ds) break;
    end
    if (!(fs && ds)) chk("sim_timeout", 32'd0, 32'd1);
    f_req = 1'b0; d_req = 1'b0;

    // Starvation guard: both held, expect D,D,D,D,F twice.
    lat = 2;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        exp_mem.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0});
        exp_done.push_back('{is_d: 1'b1, rdata: 32'h33330000});
      end
      exp_mem.push_back('{addr: 32'h200, we: 1'b0, wdata: 32'h0});
      exp_done.push_back('{is_d: 1'b0, rdata: 32'h22220000});
    end
    step(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h0;
    f_req = 1'b1; f_addr = 32'h200;
    fcnt = 0;
    for (int i = 0; i < 200; i++) begin
      smp();
      if (f_done) fcnt++;
      step();
      if (fcnt == 2) break;
    end
    if (fcnt != 2) chk("starve_timeout", fcnt, 32'd2);
    f_req = 1'b0; d_req = 1'b0;

    // Reset mid-ACCESS, then a late ack, then a normal fetch.
    lat = 0;
    exp_mem.push_back('{addr: 32'h500, we: 1'b0, wdata: 32'h0});
    step(); f_addr = 32'h500; f_req = 1'b1;
    step(); smp(); chk("r_c1_req", {31'd0, mem_req}, 32'd1);
    step(); rst = 1'b1; f_req = 1'b0;
    smp(); chk("r_c2_req", {31'd0, mem_req}, 32'd1);
    step(); rst = 1'b0;
    smp();
    chk("r_c3_req", {31'd0, mem_req}, 32'd0);
    chk("r_c3_busy", {31'd0, busy}, 32'd0);
    chk("r_c3_done", {30'd0, f_done, d_done}, 32'd0);
    chk("r_c3_f_rdata", f_rdata, 32'd0);
    chk("r_c3_d_rdata", d_rdata, 32'd0);
    step(); man_ack = 1'b1;
    smp(); chk("late_ack_busy", {31'd0, busy}, 32'd0);
    step(); man_ack = 1'b0;
    smp();
    chk("late_ack_req", {31'd0, mem_req}, 32'd0);
    chk("late_ack_busy2", {31'd0, busy}, 32'd0);
    chk("late_ack_f_rdata", f_rdata, 32'd0);
    lat = 3;
    exp_mem.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0});
    exp_done.push_back('{is_d: 1'b0, rdata: 32'hDEADBEEF});
    single(1'b0, 1'b0, 32'h100, 32'h0);

    // Stray ack in IDLE.
    step(); man_ack = 1'b1;
    smp(); chk("stray_busy", {31'd0, busy}, 32'd0);
    step(); man_ack = 1'b0;
    smp();
    chk("stray_req", {31'd0, mem_req}, 32'd0);
    chk("stray_busy2", {31'd0, busy}, 32'd0);
    chk("stray_f_rdata", f_rdata, 32'hDEADBEEF);
    chk("stray_d_rdata", d_rdata, 32'd0);

    repeat (4) step();
    chk("done_queue_empty", exp_done.size(), 32'd0);
    chk("mem_queue_empty", exp_mem.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
